// File: rtl/rule_stream_arbiter.sv
// rule_stream_arbiter: packet-granular round-robin merge of NUM_IN rule streams into one registered stream
module rule_stream_arbiter #(
    parameter int NUM_IN  = 4,
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_IN-1:0]           in_sop,
    input  logic [NUM_IN-1:0]           in_eop,
    input  logic [NUM_IN-1:0]           in_valid,
    input  logic [NUM_IN*DATA_W-1:0]    in_data,
    input  logic [NUM_IN*EMPTY_W-1:0]   in_empty,
    output logic [NUM_IN-1:0]           in_ready,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic [DATA_W-1:0]           out_data,
    output logic [EMPTY_W-1:0]          out_empty,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 stats_out_pkt,
    output logic [31:0]                 stats_sop_err
);
    localparam int PW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] grant, rr_ptr, sel, sel_rr, sel_inc;
    logic [PW:0]   idx;
    logic          found, arb_ok, ld, xfer;

    // first valid input at or after rr_ptr, wrapping at NUM_IN (not necessarily a power of 2)
    always_comb begin
        sel_rr = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NUM_IN)) idx = idx - (PW+1)'(NUM_IN);
            if (!found && in_valid[idx[PW-1:0]]) begin
                found  = 1'b1;
                sel_rr = idx[PW-1:0];
            end
        end
    end

    assign sel      = state == BUSY ? grant : sel_rr;
    assign arb_ok   = (state == BUSY) | (|in_valid);
    assign ld       = ~out_valid | out_ready;
    assign xfer     = ld & arb_ok & in_valid[sel];
    assign in_ready = (ld & arb_ok) ? NUM_IN'(1) << sel : '0;
    assign sel_inc  = sel == PW'(NUM_IN-1) ? '0 : sel + 1'b1;

    always_comb begin
        state_nxt = state;
        if (xfer) state_nxt = in_eop[sel] ? IDLE : BUSY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            rr_ptr        <= '0;
            out_valid     <= 1'b0;
            out_sop       <= 1'b0;
            out_eop       <= 1'b0;
            out_data      <= '0;
            out_empty     <= '0;
            stats_out_pkt <= '0;
            stats_sop_err <= '0;
        end else begin
            state <= state_nxt;
            if (ld) out_valid <= xfer;
            if (xfer) begin
                out_sop   <= in_sop[sel];
                out_eop   <= in_eop[sel];
                out_data  <= in_data[sel*DATA_W +: DATA_W];
                out_empty <= in_empty[sel*EMPTY_W +: EMPTY_W];
                if (state == IDLE && !in_eop[sel]) grant <= sel;
                if (in_eop[sel]) rr_ptr <= sel_inc;
                if (state == IDLE && !in_sop[sel]) stats_sop_err <= stats_sop_err + 32'd1;
            end
            if (out_valid && out_ready && out_eop) stats_out_pkt <= stats_out_pkt + 32'd1;
        end
    end
endmodule

// File: doc/rule_stream_arbiter.md
Name: rule_stream_arbiter

Overview:
- Packet-granular round-robin arbiter merging NUM_IN Avalon-ST rule streams into one output stream.
- Each input is the usr/rule output of one port-group instance; the output feeds the single downstream rule consumer.
- A grant is held from sop to eop, so packets never interleave.
- One registered output stage and a per-packet output counter.

Parameters:
- NUM_IN, 4, number of requesting streams (2..16).
- DATA_W, 512, flit data width.
- EMPTY_W, 6, empty field width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_sop  in  NUM_IN  per-input start of packet.
- in_eop  in  NUM_IN  per-input end of packet.
- in_valid  in  NUM_IN  per-input flit valid.
- in_data  in  NUM_IN*DATA_W  input i occupies bits [i*DATA_W +: DATA_W].
- in_empty  in  NUM_IN*EMPTY_W  input i occupies bits [i*EMPTY_W +: EMPTY_W].
- in_ready  out  NUM_IN  per-input ready; at most one bit high in any cycle.
- out_sop  out  1  registered sop.
- out_eop  out  1  registered eop.
- out_data  out  DATA_W  registered data.
- out_empty  out  EMPTY_W  registered empty.
- out_valid  out  1  registered valid.
- out_ready  in  1  downstream ready.
- stats_out_pkt  out  32  count of eop flits accepted downstream.
- stats_sop_err  out  32  count of flits granted in IDLE without sop.

Behaviour:
- Handshake: a transfer occurs when valid&ready on the same cycle.
- Output stage: ld = ~out_valid | out_ready. in_ready[i] = ld & (i == sel) & arb_ok. Here sel and arb_ok are combinational, derived from state, as defined below.
- State machine, reg state in {IDLE, BUSY}, reg grant [clog2(NUM_IN)], reg rr_ptr [clog2(NUM_IN)].
- IDLE:
  - sel = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_IN.
  - arb_ok = |in_valid.
  - If a flit from sel transfers and in_eop[sel] = 0: grant <= sel, go BUSY.
  - If it transfers with in_eop = 1 (single-flit packet): stay IDLE, rr_ptr <= sel+1 mod NUM_IN.
  - If the accepted flit has in_sop = 0: stats_sop_err += 1. The flit is still forwarded, and is not altered or dropped.
- BUSY:
  - sel = grant. arb_ok = 1. Other inputs see in_ready = 0 regardless of their valid.
  - On transfer with in_eop[grant] = 1: go IDLE, rr_ptr <= grant+1 mod NUM_IN.
  - Not-valid cycles on the granted input are bubbles; the grant is held indefinitely.
- Wrap-around: rr_ptr increment wraps at NUM_IN, which need not be a power of 2 (explicit compare-to-NUM_IN-1).
- Latency: an accepted input flit appears on out_* the next cycle. Back-to-back packets from different inputs run with no idle cycle (re-arbitration happens in the same cycle the eop moves into the register).
- Output register:
  - On ld & any transfer: out_* <= selected input fields, out_valid <= 1.
  - On ld & no transfer: out_valid <= 0, other fields hold.
  - When out_valid & ~out_ready: all out_* hold and all in_ready = 0.
- Counters:
  - stats_out_pkt += 1 on out_valid & out_ready & out_eop.
  - Both counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- Reset: state = IDLE, grant = 0, rr_ptr = 0, out_valid = 0, out_sop = out_eop = 0, out_data = 0, out_empty = 0, stats counters = 0. in_ready follows combinationally; after reset, inputs valid in that cycle may be granted.
- Reset mid-packet: the packet is abandoned, and a downstream packet may be truncated with no eop. Upstream is responsible for flushing.
- Simultaneous in_valid on all inputs with rr_ptr = k: input k wins.

Test Plan:
- Single input 0 sends a 3-flit packet, out_ready = 1 -> out_* reproduces the flits at cycles +1..+3; in_ready = 0001 throughout; stats_out_pkt = 1.
- All 4 inputs hold 2-flit packets simultaneously from reset -> outputs ordered in0, in1, in2, in3 with no bubbles; no interleaving; rr_ptr = 0 after the 4th eop; stats_out_pkt = 4.
- Input 2 is granted mid-packet and input 1 asserts valid -> in_ready[1] stays 0 until input 2's eop is transferred; input 1 is then granted next with no idle cycle.
- out_ready held 0 for 5 cycles with out_valid = 1 -> out_data is stable and all in_ready = 0. After release, no flit is lost or duplicated (compare against the scoreboard).
- Input 3 sends a flit with sop = 0 in IDLE -> it is forwarded and stats_sop_err = 1. Separately, rst asserted mid-packet -> out_valid = 0 and both stats counters = 0 the next cycle; a new packet from input 0 is accepted immediately.
- Single-flit packets (sop = eop = 1) from inputs 1 and 3 continuously -> alternating 1, 3, 1, 3 output at full rate.
